// File: rtl/int_sched.sv
// int_sched: edge-latched, fixed-priority interrupt scheduler with in-service tracking for ERET sequencing.
// Define INT_SCHED_NESTING_EN to let a higher-priority source preempt handlers already in service.
module int_sched #(
    parameter int          N_SRC      = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
    parameter int          HOLD_CYC   = 3,
    localparam int         IW         = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SRC-1:0]  src,
    input  logic [N_SRC-1:0]  irq_mask,
    input  logic              ie,
    input  logic              int_ack,
    input  logic              eret_done,
    output logic              irq,
    output logic [IW-1:0]     irq_id,
    output logic [31:0]       irq_vector,
    output logic [N_SRC-1:0]  pending,
    output logic [N_SRC-1:0]  in_service
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t             state;
    logic [N_SRC-1:0]   src_q;
    logic [3:0]         hold_cnt;

    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   above;
    logic [N_SRC-1:0]   top_is;
    logic [N_SRC-1:0]   eligible;
    logic [N_SRC-1:0]   ack_set;
    logic [N_SRC-1:0]   eret_clr;
    logic [IW-1:0]      winner;
    logic               any_eligible;

    always_comb begin
        rise   = src & ~src_q;
        above  = '1;
        top_is = '0;
        // above[] keeps only indices strictly higher than the current level
        for (int i = 0; i < N_SRC; i++) begin
            if (in_service[i]) begin
                top_is    = '0;
                top_is[i] = 1'b1;
                for (int j = 0; j <= i; j++) begin
                    above[j] = 1'b0;
                end
            end
        end
        eligible = pending & irq_mask & above & {N_SRC{ie}};
`ifndef INT_SCHED_NESTING_EN
        if (|in_service) begin
            eligible = '0;
        end
`endif
        winner = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (eligible[i]) begin
                winner = IW'(i);
            end
        end
        any_eligible = |eligible;
        ack_set = '0;
        if (state == REQ && int_ack) begin
            ack_set[irq_id] = 1'b1;
        end
        eret_clr = eret_done ? top_is : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            src_q      <= '0;
            pending    <= '0;
            in_service <= '0;
            hold_cnt   <= '0;
            irq        <= 1'b0;
            irq_id     <= '0;
            irq_vector <= VEC_BASE;
        end else begin
            src_q <= src;
            // a new edge in the acknowledge cycle re-arms the source
            pending    <= (pending & ~ack_set) | rise;
            in_service <= (in_service & ~eret_clr) | ack_set;
            case (state)
                IDLE: begin
                    if (any_eligible) begin
                        state      <= REQ;
                        irq        <= 1'b1;
                        irq_id     <= winner;
                        irq_vector <= VEC_BASE + 32'(winner) * VEC_STRIDE;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        state    <= HOLD;
                        irq      <= 1'b0;
                        hold_cnt <= 4'(HOLD_CYC - 1);
                    end else if (!ie || !irq_mask[irq_id]) begin
                        state <= IDLE;
                        irq   <= 1'b0;
                    end
                end
                HOLD: begin
                    if (hold_cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_sched.sv
// tb_int_sched: table-driven directed vectors, hand sequences and randomized traffic against a timestamp-based model.
// Builds with or without INT_SCHED_NESTING_EN; the model follows the same define.
module tb_int_sched;

    localparam int          N      = 3;
    localparam int          HOLD   = 3;
    localparam logic [31:0] BASE   = 32'h0000_0100;
    localparam logic [31:0] STRIDE = 32'h0000_0010;
`ifdef INT_SCHED_NESTING_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  src, irq_mask;
    logic        ie, int_ack, eret_done;
    logic        irq;
    logic [1:0]  irq_id;
    logic [31:0] irq_vector;
    logic [2:0]  pending, in_service;

    int_sched #(.N_SRC(N), .VEC_BASE(BASE), .VEC_STRIDE(STRIDE), .HOLD_CYC(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .src(src), .irq_mask(irq_mask), .ie(ie),
        .int_ack(int_ack), .eret_done(eret_done), .irq(irq), .irq_id(irq_id),
        .irq_vector(irq_vector), .pending(pending), .in_service(in_service)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: a presented request is tracked as a flag; the post-acknowledge
    // guard is a timestamp (edge count) before which nothing new may be presented.
    logic [2:0] m_pend, m_is, m_srcq;
    bit         m_irq;
    int         m_id;
    int         m_cyc = 0;
    int         m_ready_at;

    task automatic model_reset();
        m_pend = '0; m_is = '0; m_srcq = '0;
        m_irq = 1'b0; m_id = 0; m_ready_at = 0;
    endtask

    task automatic model_edge();
        int level = -1;
        int win = -1;
        logic [2:0] clr = '0, setb = '0, er = '0;
        m_cyc++;
        for (int i = 0; i < N; i++) if (m_is[i]) level = i;
        if (m_irq) begin
            if (int_ack) begin
                clr[m_id] = 1'b1; setb[m_id] = 1'b1;
                m_irq = 1'b0;
                m_ready_at = m_cyc + HOLD + 1;
            end else if (!ie || !irq_mask[m_id]) begin
                m_irq = 1'b0;
            end
        end else if (m_cyc >= m_ready_at) begin
            for (int i = 0; i < N; i++)
                if (m_pend[i] && irq_mask[i] && ie && i > level && (NEST || m_is == 3'b000)) win = i;
            if (win >= 0) begin
                m_irq = 1'b1;
                m_id = win;
            end
        end
        if (eret_done && level >= 0) er[level] = 1'b1;
        m_is   = (m_is & ~er) | setb;
        m_pend = (m_pend & ~clr) | (src & ~m_srcq);
        m_srcq = src;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("irq", 32'(irq), 32'(m_irq));
        chk("irq_id", 32'(irq_id), 32'(m_id));
        chk("irq_vector", irq_vector, BASE + 32'(m_id) * STRIDE);
        chk("pending", 32'(pending), 32'(m_pend));
        chk("in_service", 32'(in_service), 32'(m_is));
    endtask

    task automatic chk_reset_vals();
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_irq_id", 32'(irq_id), 32'd0);
        chk("rst_vector", irq_vector, BASE);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_in_service", 32'(in_service), 32'd0);
    endtask

    // Drive inputs, take one rising edge, advance the model, leave time at edge+1.
    task automatic drive(input logic [2:0] s, input logic [2:0] m, input logic e, input logic a, input logic r);
        src = s; irq_mask = m; ie = e; int_ack = a; eret_done = r;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step(input logic [2:0] s, input logic [2:0] m, input logic e, input logic a, input logic r);
        drive(s, m, e, a, r);
        chk_model();
    endtask

    // Reset in the middle of a cycle, check immediately, release on a falling edge.
    task automatic async_reset(input logic [2:0] s_during);
        #2;
        rst_n = 1'b0;
        src = s_during;
        model_reset();
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0] s;
        logic [2:0] m;
        logic       e, a, r;
        logic       x_irq;
        logic [1:0] x_id;
        logic [2:0] x_pend;
        logic [2:0] x_is;
    } vec_t;

    function automatic vec_t mk(logic [2:0] s, logic [2:0] m, logic e, logic a, logic r,
                                logic x_irq, logic [1:0] x_id, logic [2:0] x_pend, logic [2:0] x_is);
        vec_t v;
        v.s = s; v.m = m; v.e = e; v.a = a; v.r = r;
        v.x_irq = x_irq; v.x_id = x_id; v.x_pend = x_pend; v.x_is = x_is;
        return v;
    endfunction

    vec_t tbl[29];

    initial begin
        // single source, ack, guard window, eret
        tbl[0]  = mk(3'b001, 3'b111, 1, 0, 0,  0, 2'd0, 3'b001, 3'b000);
        tbl[1]  = mk(3'b001, 3'b111, 1, 0, 0,  1, 2'd0, 3'b001, 3'b000);
        tbl[2]  = mk(3'b001, 3'b111, 1, 1, 0,  0, 2'd0, 3'b000, 3'b001);
        tbl[3]  = mk(3'b000, 3'b111, 1, 0, 0,  0, 2'd0, 3'b000, 3'b001);
        tbl[4]  = mk(3'b000, 3'b111, 1, 0, 0,  0, 2'd0, 3'b000, 3'b001);
        tbl[5]  = mk(3'b000, 3'b111, 1, 0, 0,  0, 2'd0, 3'b000, 3'b001);
        tbl[6]  = mk(3'b000, 3'b111, 1, 0, 0,  0, 2'd0, 3'b000, 3'b001);
        tbl[7]  = mk(3'b000, 3'b111, 1, 0, 1,  0, 2'd0, 3'b000, 3'b000);
        // priority: sources 0 and 2 together
        tbl[8]  = mk(3'b101, 3'b111, 1, 0, 0,  0, 2'd0, 3'b101, 3'b000);
        tbl[9]  = mk(3'b101, 3'b111, 1, 0, 0,  1, 2'd2, 3'b101, 3'b000);
        tbl[10] = mk(3'b000, 3'b111, 1, 1, 0,  0, 2'd2, 3'b001, 3'b100);
        tbl[11] = mk(3'b000, 3'b111, 1, 0, 0,  0, 2'd2, 3'b001, 3'b100);
        tbl[12] = mk(3'b000, 3'b111, 1, 0, 0,  0, 2'd2, 3'b001, 3'b100);
        tbl[13] = mk(3'b000, 3'b111, 1, 0, 0,  0, 2'd2, 3'b001, 3'b100);
        tbl[14] = mk(3'b000, 3'b111, 1, 0, 0,  0, 2'd2, 3'b001, 3'b100);
        tbl[15] = mk(3'b000, 3'b111, 1, 0, 1,  0, 2'd2, 3'b001, 3'b000);
        tbl[16] = mk(3'b000, 3'b111, 1, 0, 0,  1, 2'd0, 3'b001, 3'b000);
        // withdraw on ie, re-present
        tbl[17] = mk(3'b000, 3'b111, 0, 0, 0,  0, 2'd0, 3'b001, 3'b000);
        tbl[18] = mk(3'b000, 3'b111, 0, 0, 0,  0, 2'd0, 3'b001, 3'b000);
        tbl[19] = mk(3'b000, 3'b111, 1, 0, 0,  1, 2'd0, 3'b001, 3'b000);
        // withdraw on mask; masked source stays pending
        tbl[20] = mk(3'b000, 3'b110, 1, 0, 0,  0, 2'd0, 3'b001, 3'b000);
        tbl[21] = mk(3'b010, 3'b110, 1, 0, 0,  0, 2'd0, 3'b011, 3'b000);
        tbl[22] = mk(3'b010, 3'b110, 1, 0, 0,  1, 2'd1, 3'b011, 3'b000);
        // ack + ignored eret + fresh src[2] edge in the same cycle
        tbl[23] = mk(3'b110, 3'b110, 1, 1, 1,  0, 2'd1, 3'b101, 3'b010);
        tbl[24] = mk(3'b110, 3'b111, 1, 0, 0,  0, 2'd1, 3'b101, 3'b010);
        tbl[25] = mk(3'b110, 3'b111, 1, 0, 1,  0, 2'd1, 3'b101, 3'b000);
        tbl[26] = mk(3'b110, 3'b111, 1, 0, 0,  0, 2'd1, 3'b101, 3'b000);
        tbl[27] = mk(3'b110, 3'b111, 1, 0, 0,  1, 2'd2, 3'b101, 3'b000);
        tbl[28] = mk(3'b000, 3'b111, 1, 1, 0,  0, 2'd2, 3'b001, 3'b100);

        rst_n = 1'b0;
        src = '0; irq_mask = '0; ie = 1'b0; int_ack = 1'b0; eret_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 29; k++) begin
            drive(tbl[k].s, tbl[k].m, tbl[k].e, tbl[k].a, tbl[k].r);
            chk($sformatf("t%0d_irq", k), 32'(irq), 32'(tbl[k].x_irq));
            chk($sformatf("t%0d_id", k), 32'(irq_id), 32'(tbl[k].x_id));
            chk($sformatf("t%0d_vec", k), irq_vector, BASE + 32'(tbl[k].x_id) * STRIDE);
            chk($sformatf("t%0d_pend", k), 32'(pending), 32'(tbl[k].x_pend));
            chk($sformatf("t%0d_is", k), 32'(in_service), 32'(tbl[k].x_is));
        end

        // reset while a request is presented: source 0 is still pending
        step(3'b000, 3'b111, 1, 0, 1);
        begin
            int budget = 10;
            while (!irq && budget > 0) begin
                step(3'b000, 3'b111, 1, 0, 0);
                budget--;
            end
            chk("reach_req_timeout", 32'(irq), 32'd1);
        end
        async_reset(3'b000);
        repeat (4) begin
            step(3'b000, 3'b111, 1, 0, 0);
            chk("post_rst_no_irq", 32'(irq), 32'd0);
        end

`ifdef INT_SCHED_NESTING_EN
        step(3'b001, 3'b111, 1, 0, 0);
        step(3'b001, 3'b111, 1, 0, 0);
        chk("nest_id0", 32'(irq_id), 32'd0);
        step(3'b000, 3'b111, 1, 1, 0);
        chk("nest_is001", 32'(in_service), 32'b001);
        repeat (3) step(3'b000, 3'b111, 1, 0, 0);
        step(3'b010, 3'b111, 1, 0, 0);
        step(3'b010, 3'b111, 1, 0, 0);
        chk("nest_irq1", 32'(irq), 32'd1);
        chk("nest_id1", 32'(irq_id), 32'd1);
        step(3'b000, 3'b111, 1, 1, 0);
        chk("nest_is011", 32'(in_service), 32'b011);
        repeat (3) step(3'b000, 3'b111, 1, 0, 0);
        step(3'b000, 3'b111, 1, 0, 1);
        chk("nest_eret1", 32'(in_service), 32'b001);
        step(3'b000, 3'b111, 1, 0, 1);
        chk("nest_eret2", 32'(in_service), 32'b000);
        // ack + eret together with in_service=001 and source 2 presented
        step(3'b001, 3'b111, 1, 0, 0);
        step(3'b001, 3'b111, 1, 0, 0);
        step(3'b000, 3'b111, 1, 1, 0);
        repeat (3) step(3'b000, 3'b111, 1, 0, 0);
        step(3'b100, 3'b111, 1, 0, 0);
        step(3'b100, 3'b111, 1, 0, 0);
        chk("sim_id2", 32'(irq_id), 32'd2);
        step(3'b000, 3'b111, 1, 0, 0);
        step(3'b100, 3'b111, 1, 1, 1);
        chk("sim_is100", 32'(in_service), 32'b100);
        chk("sim_pend2", 32'(pending[2]), 32'd1);
`endif

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [2:0] s, m;
            logic e, a, r;
            s = 3'($urandom_range(0, 7));
            m = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            e = ($urandom_range(0, 9) != 0);
            a = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 7) == 0);
            step(s, m, e, a, r);
            if ($urandom_range(0, 299) == 0) async_reset(3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/int_sched.md
# int_sched

Multi-source interrupt scheduler for the pipelined MIPS32 core. It latches edge-triggered requests from `N_SRC` external sources, arbitrates them by fixed priority, and presents one request at a time to the ID-stage control on `irq`, together with the handler vector. It tracks which sources are in service so that nesting and ERET return are sequenced correctly. It sits between the board-level interrupt inputs and the control/CP0 logic: `irq` drives the control unit's `int`, and the control unit's `inting` returns as `int_ack`.

## Interface
- `N_SRC`, default 3: number of interrupt sources; index `N_SRC-1` has the highest priority.
- `VEC_BASE`, default 32'h0000_0100: handler vector of source 0.
- `VEC_STRIDE`, default 32'h0000_0010: vector spacing per source index.
- `HOLD_CYC`, default 3: guard cycles after an acknowledge before a new request may be raised (pipeline drain), range 1..15.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `src`, in, N_SRC: level inputs, already synchronous to `clk`; a rising edge requests service.
- `irq_mask`, in, N_SRC: per-source enable; 1 means enabled.
- `ie`, in, 1: global enable (CP0 IE bit 0).
- `int_ack`, in, 1: one-cycle pulse; the pipeline has taken the presented interrupt.
- `eret_done`, in, 1: one-cycle pulse; an ERET has retired.
- `irq`, out, 1: request to control (`int`).
- `irq_id`, out, $clog2(N_SRC): index of the presented source.
- `irq_vector`, out, 32: `VEC_BASE + irq_id*VEC_STRIDE`, truncated to 32 bits.
- `pending`, out, N_SRC: latched, unserviced requests.
- `in_service`, out, N_SRC: sources currently being handled.

## Operation
- Edge detect: a registered copy `src_q` is kept. `pending[i]` is set when `src[i] & ~src_q[i]`. It is cleared when source i is acknowledged. If set and clear happen in the same cycle, set wins.
- Masking never clears `pending`; a masked source stays pending until it is unmasked and serviced.
- Current level: index of the highest set `in_service` bit, or -1 if `in_service` is 0.
- Eligible set: `pending & irq_mask`, restricted to indices above the current level, and gated by `ie`.
- Winner: the highest eligible index.
- FSM states: IDLE, REQ, HOLD.
  - IDLE: if the eligible set is non-empty, latch the winner into `irq_id` and go to REQ.
  - REQ: `irq`=1 and `irq_id` is frozen. A newly arriving higher-priority source does not replace it.
    - On `int_ack`: clear `pending[irq_id]`, set `in_service[irq_id]`, load the hold counter with `HOLD_CYC-1`, and go to HOLD.
    - Otherwise, if `ie`=0 or `irq_mask[irq_id]`=0: withdraw and go to IDLE.
    - `int_ack` takes precedence over withdrawal in the same cycle.
  - HOLD: `irq`=0. The counter decrements each cycle; at 0 the FSM goes to IDLE.
- `eret_done` clears the highest set `in_service` bit, in any state. If `in_service` is 0, it is ignored.
- `eret_done` together with `int_ack` in the same cycle: clear the highest bit of the old `in_service`, then set the new bit.
- `int_ack` outside REQ is ignored.
- Reset (at any time, including mid-REQ or mid-HOLD): `pending`, `in_service`, and `src_q` go to 0; FSM goes to IDLE; `irq`=0; `irq_id`=0; `irq_vector`=`VEC_BASE`; hold counter goes to 0.

## Timing
- `irq`, `irq_id`, and `irq_vector` are registered outputs; `irq` equals (state==REQ).
- Latency from a `src` rising edge (seen at edge k) to `irq`: `pending` is set at edge k, REQ is entered at edge k+1, so `irq`=1 is visible in the cycle after edge k+1. This is a 2-cycle minimum.
- `irq_id` and `irq_vector` are stable for the entire time `irq`=1.
- `int_ack` sampled at edge a: `irq` falls after edge a. The earliest next `irq` is visible after edge a+`HOLD_CYC`+1.
- Withdrawal because `ie`=0 takes effect at the next edge; `irq` stays high for at most one cycle after `ie` falls.

## Configuration
- `INT_SCHED_NESTING_EN` defined: preemption as described; a source above the current level may be presented while others are in service.
- Not defined: the eligible set is empty whenever `in_service` is non-zero. At most one `in_service` bit is ever set, and `eret_done` clears it. Priority arbitration among pending sources is unchanged.

## Test plan
- Single source: `src[0]` rises, `ie`=1, mask=3'b111 -> `irq`=1 two cycles later, `irq_id`=0, `irq_vector`=32'h100. After `int_ack`, `pending`=0, `in_service`=3'b001, and `irq` stays 0 for 3 cycles.
- Priority: `src[0]` and `src[2]` rise in the same cycle -> `irq_id`=2, vector 32'h120. After ack + HOLD, `irq_id`=0 is presented only with nesting disabled after `eret_done`; with nesting enabled it is never presented while `in_service`=3'b100.
- Nesting (`INT_SCHED_NESTING_EN`): `in_service`=3'b001, then `src[1]` rises -> `irq_id`=1 presented. After ack, `in_service`=3'b011. Two `eret_done` pulses -> 3'b001, then 3'b000.
- Withdraw: in REQ, drop `ie` -> `irq`=0 after the next edge, `pending` unchanged. Raise `ie` -> request is re-presented 1 cycle later.
- Simultaneous events: `int_ack`+`eret_done` with `in_service`=3'b001 and `irq_id`=2 -> `in_service`=3'b100. A new `src[2]` edge in the ack cycle leaves `pending[2]`=1.
- Reset mid-REQ: assert `rst_n`=0 -> `irq`=0, `pending`=0, `in_service`=0 immediately. After release, no request until a new edge.
